// File: rtl/uart_rx_deframer_if.sv
// Signal bundle between the serial deframer and its FIFO/host side.
// The master modport belongs to the deframer; slave is the environment driving it.
interface uart_rx_deframer_if;
    logic       rxd;
    logic       full;
    logic       clear_drop_n;
    logic [8:0] data_out;
    logic       write_n;
    logic       frame_err;
    logic       dropped;
    logic       busy;

    modport master (
        input  rxd, full, clear_drop_n,
        output data_out, write_n, frame_err, dropped, busy
    );

    modport slave (
        output rxd, full, clear_drop_n,
        input  data_out, write_n, frame_err, dropped, busy
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// Oversampling 8E1 UART receiver that packs each frame into {parity_err, byte}
// and pushes it into a downstream FIFO through an active-low write strobe.
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 434
) (
    input logic                 clk,
    input logic                 rst,
    uart_rx_deframer_if.master  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [1:0]    sync_reg;
    logic          rx_s;
    logic [2:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          perr_reg;
    logic [8:0]    data_out_reg;
    logic          write_n_reg;
    logic          frame_err_reg;
    logic          dropped_reg;
    logic          tick;

    // Both flops reset high so a reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], bus.rxd};
        end
    end

    assign rx_s = sync_reg[1];

    // The start bit is checked at its middle; every later bit one full period on.
    assign tick = (state_reg == START) ? (cnt_reg == HALF_LAST) : (cnt_reg == FULL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'h00;
            perr_reg      <= 1'b0;
            data_out_reg  <= 9'h000;
            write_n_reg   <= 1'b1;
            frame_err_reg <= 1'b0;
            dropped_reg   <= 1'b0;
        end else begin
            write_n_reg   <= 1'b1;
            frame_err_reg <= 1'b0;
            if (!bus.clear_drop_n) begin
                dropped_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        cnt_reg     <= '0;
                        bit_cnt_reg <= 3'd0;
                        state_reg   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt_reg     <= '0;
                        shift_reg   <= {rx_s, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= PARITY;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick) begin
                        cnt_reg   <= '0;
                        perr_reg  <= (^shift_reg) ^ rx_s;
                        state_reg <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                        if (!rx_s) begin
                            frame_err_reg <= 1'b1;
                        end else if (!bus.full) begin
                            data_out_reg <= {perr_reg, shift_reg};
                            write_n_reg  <= 1'b0;
                        end else begin
                            // Placed after the clear so a simultaneous set wins.
                            dropped_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_out_reg;
    assign bus.write_n   = write_n_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.dropped   = dropped_reg;
    assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: frames are serialised on the line and the
// expected FIFO words are queued, then matched as the write strobe fires.
module tb_uart_rx_deframer;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_deframer_if bus ();

    uart_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         wr_count = 0;
    int         fe_count = 0;
    int         wr_cyc   = 0;
    int         start_cyc = 0;
    logic [8:0] sb_q[$];
    logic       prev_wn = 1'b1;
    logic       prev_fe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard side: every write strobe must match the oldest queued word.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.write_n === 1'b0) begin
                wr_count++;
                wr_cyc = cyc;
                check("write_width", {31'd0, prev_wn}, 32'd1);
                check("write_expected", {31'd0, sb_q.size() > 0}, 32'd1);
                if (sb_q.size() > 0) check("data_out", {23'd0, bus.data_out}, {23'd0, sb_q.pop_front()});
            end
            if (bus.frame_err === 1'b1) begin
                fe_count++;
                check("frame_err_width", {31'd0, prev_fe}, 32'd0);
            end
        end
        prev_wn = bus.write_n;
        prev_fe = bus.frame_err;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        bus.rxd = v;
        repeat (CPB) @(negedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        start_cyc = cyc + 1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(stop);
        bus.rxd = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.rxd = 1'b1;
        bus.full = 1'b0;
        bus.clear_drop_n = 1'b1;
        idle(3);
        check("rst_data_out", {23'd0, bus.data_out}, 32'h000);
        check("rst_write_n", {31'd0, bus.write_n}, 32'd1);
        check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_dropped", {31'd0, bus.dropped}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        idle(5);

        // Good frame with latency measurement
        sb_q.push_back(9'h0A5);
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(4);
        lat = wr_cyc - start_cyc;
        check("good_writes", wr_count, 32'd1);
        check("good_latency_170pm1", {31'd0, (lat >= 169 && lat <= 171)}, 32'd1);
        check("good_frame_err", fe_count, 32'd0);
        check("good_dropped", {31'd0, bus.dropped}, 32'd0);

        // Parity error still writes, flagged in bit 8
        sb_q.push_back(9'h13C);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(4);
        check("perr_writes", wr_count, 32'd2);

        // Back-to-back frames, no idle gap
        sb_q.push_back(9'h000);
        sb_q.push_back(9'h0FF);
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(4);
        check("b2b_writes", wr_count, 32'd4);
        check("b2b_last_data", {23'd0, bus.data_out}, 32'h0FF);

        // Framing error: no write, data held
        send_frame(8'h55, 1'b0, 1'b0);
        idle(30);
        check("ferr_count", fe_count, 32'd1);
        check("ferr_no_write", wr_count, 32'd4);
        check("ferr_data_held", {23'd0, bus.data_out}, 32'h0FF);
        check("ferr_busy", {31'd0, bus.busy}, 32'd0);

        // Glitch shorter than half a bit
        bus.rxd = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_high", {31'd0, bus.busy}, 32'd1);
        bus.rxd = 1'b1;
        repeat (8) @(negedge clk);
        check("glitch_busy_low", {31'd0, bus.busy}, 32'd0);
        idle(20);
        check("glitch_no_write", wr_count, 32'd4);
        check("glitch_no_ferr", fe_count, 32'd1);

        // FIFO full drops the frame and sets the sticky flag
        bus.full = 1'b1;
        send_frame(8'h12, 1'b0, 1'b1);
        idle(4);
        check("full_no_write", wr_count, 32'd4);
        check("full_dropped", {31'd0, bus.dropped}, 32'd1);
        bus.full = 1'b0;
        idle(10);
        check("dropped_held", {31'd0, bus.dropped}, 32'd1);
        bus.clear_drop_n = 1'b0;
        idle(1);
        bus.clear_drop_n = 1'b1;
        idle(1);
        check("dropped_cleared", {31'd0, bus.dropped}, 32'd0);
        sb_q.push_back(9'h034);
        send_frame(8'h34, 1'b1, 1'b1);
        idle(4);
        check("after_full_writes", wr_count, 32'd5);
        check("after_full_data", {23'd0, bus.data_out}, 32'h034);

        // Reset in the middle of data bits of 0x77; transmitter abandons the frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        bus.rxd = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_data_out", {23'd0, bus.data_out}, 32'h000);
        check("midrst_write_n", {31'd0, bus.write_n}, 32'd1);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("midrst_dropped", {31'd0, bus.dropped}, 32'd0);
        idle(3);
        rst = 1'b0;
        idle(200);
        check("midrst_no_write", wr_count, 32'd5);
        sb_q.push_back(9'h081);
        send_frame(8'h81, 1'b0, 1'b1);
        idle(4);
        check("post_rst_writes", wr_count, 32'd6);
        check("post_rst_data", {23'd0, bus.data_out}, 32'h081);
        check("queue_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Serial receive front end that feeds the 16x9 status FIFO. It oversamples an asynchronous 8E1 serial line and rebuilds each frame into a 9-bit word, {parity error, data byte}. It drives the FIFO's active-low write strobe and respects the FIFO's Full flag. It sits directly upstream of the FIFO; its DataOut/WriteN pair connects straight to the FIFO's DataIn/Write.

## Interface
- CLKS_PER_BIT, 434, Clock cycles per serial bit: 50 MHz / 115200 baud. Must be even and ≥ 8.
- Clock  in  1  System clock, rising-edge active
- Reset  in  1  Asynchronous, active-high reset
- RxD  in  1  Serial line, idle high, LSB first, 8 data bits, even parity, 1 stop bit
- Full  in  1  FIFO Full flag; sampled at stop-bit time
- ClearDrop  in  1  Active-low; clears the Dropped flag
- DataOut  out  9  {ParityErr, Data[7:0]}; registered and held until the next frame completes
- WriteN  out  1  Active-low FIFO write strobe, exactly one cycle wide per accepted frame
- FrameErr  out  1  One-cycle high pulse when the stop bit samples 0
- Dropped  out  1  Sticky flag; set when a good frame arrives while Full=1
- Busy  out  1  High while the FSM is not in IDLE

## Operation
- RxD passes through a 2-flop synchronizer. Both flops reset to 1; the synchronized signal is rx_s.
- Baud counter width is clog2(CLKS_PER_BIT). Bit counter is 3 bits. Shift register is 8 bits and shifts right, so the first data bit received lands in Data[0].
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - When rx_s==0, go to START and clear the baud counter.
- START:
  - When the counter reaches CLKS_PER_BIT/2-1, sample rx_s.
  - If 0: go to DATA, clear the counter and the bit counter.
  - If 1 (glitch): return to IDLE. No outputs change.
- DATA:
  - Sample every time the counter reaches CLKS_PER_BIT-1.
  - After the 8th sample (bit counter wraps 7→0), go to PARITY.
- PARITY:
  - Sample at CLKS_PER_BIT-1.
  - Store perr = XOR(data byte, parity bit). Nonzero means a parity error under even parity.
- STOP: sample at CLKS_PER_BIT-1, then always return to IDLE on the same edge.
  - rx_s==0: pulse FrameErr. No write; DataOut and WriteN are unchanged.
  - rx_s==1 and Full==0: load DataOut <= {perr, byte} and drive WriteN <= 0.
  - rx_s==1 and Full==1: set Dropped. DataOut and WriteN are unchanged.
- A parity error does not block the write; it is reported in DataOut[8].
- The FSM returns to IDLE at mid-stop-bit. A new start edge is accepted from the next cycle, so back-to-back frames are tolerated.
- Dropped clears on any cycle where ClearDrop==0. If a set event and a clear happen in the same cycle, set wins.
- Reset mid-frame aborts the frame with no write. The next frame is received normally.

## Timing
- Reset values:
  - DataOut=9'h000
  - WriteN=1, FrameErr=0, Dropped=0, Busy=0
  - FSM=IDLE, synchronizer flops=1, all counters 0
- WriteN goes low on the same edge that samples the stop bit. It returns high on the next edge, giving a width of exactly 1 cycle. DataOut is valid from that edge onward.
- Latency, measured from the first Clock edge that registers RxD low in sync flop 1 to the WriteN falling edge: 2 + CLKS_PER_BIT/2 + 10·CLKS_PER_BIT cycles. The bench allows ±1 cycle.
- FrameErr is exactly 1 cycle wide, on the stop-sample edge.
- Busy rises on the edge that enters START and falls on the edge that returns to IDLE.
- Full is sampled only on the stop-sample edge. Changes to Full at any other time have no effect.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- Good frame: byte 0xA5 with parity bit 0. Expect:
  - one WriteN low pulse of 1 cycle, with DataOut=9'h0A5
  - FrameErr=0, Dropped=0
  - WriteN falling edge at 170±1 cycles after the start edge is registered
- Bad parity: byte 0x3C with parity bit 1. Expect:
  - DataOut=9'h13C, with one WriteN pulse
  - Next, send back-to-back 0x00 and 0xFF with correct parity and no idle gap. Expect two pulses carrying 9'h000 and then 9'h0FF.
- Framing error: byte 0x55 with stop bit 0. Expect:
  - FrameErr high for 1 cycle and no WriteN pulse
  - DataOut holds its previous value
  - Busy=0 afterward
- Glitch rejection: RxD low for 4 cycles, then high. Expect:
  - no WriteN pulse and no FrameErr
  - Busy high briefly, back in IDLE within 11 cycles
- Full handling: hold Full=1 and send 0x12. Expect:
  - no WriteN pulse, Dropped=1 and held
  - drive ClearDrop low for 1 cycle, then Dropped=0
  - with Full=0, send 0x34: DataOut=9'h034 and one pulse
- Reset mid-frame: assert Reset for 3 cycles during the data bits of 0x77. Expect:
  - all outputs return to their reset values immediately
  - no write for the aborted frame
  - a following 0x81 frame yields DataOut=9'h081
